dev_interface_7seg_scan: RTL and testbench
==========================================

# dev_interface_7seg_scan

Four-digit multiplexed seven-segment display peripheral on the PICO16a CPU bus. It is the downstream neighbour of the single-digit 7seg interface. The CPU writes a 16-bit value; the block decodes each 4-bit nibble to segments itself and time-multiplexes the four digits onto one shared segment bus, with blanking gaps between digits to prevent ghosting. A frame-boundary shadow register prevents a CPU write from tearing a displayed frame.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: cycles each digit is lit. Must be ≥1.
- `BLANK_DIV`, default 500: cycles all digits are off between digits. Must be ≥1.

Ports:
- `cpu_clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `from_cpu`  in  16  CPU write data.
- `cs`  in  1  device select.
- `we`  in  1  write enable; a write occurs when `cs && we` at a `cpu_clk` rising edge.
- `to_cpu`  out  16  read-back of the pending register.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `dig_n`  out  4  digit enables, active-low; bit k selects digit k (digit 0 is the least significant nibble).

## Operation

- Registers:
  - `pend[15:0]`: CPU-written value.
  - `shadow[15:0]`: value being displayed.
  - `digit[1:0]`: current digit index.
  - `cnt`: phase counter, wide enough for `max(SCAN_DIV, BLANK_DIV) - 1`.
  - `state`: one of `S_BLANK` or `S_ON`.
- Write: when `cs && we`, `pend <= from_cpu`. Otherwise `pend` holds.
- Read: `to_cpu = pend`, combinational.
- Hex decode, active-low `{g..a}`:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
- FSM:
  - `S_BLANK`:
    - `dig_n=4'b1111`, `seg=7'h7F`, `cnt` increments.
    - When `cnt==BLANK_DIV-1`: go to `S_ON`, `cnt<=0`, `dig_n[digit]<=0`, `seg<=decode(nibble digit)`.
    - If `digit==0` at this transition, also `shadow<=pend`, and the nibble is taken from `pend[3:0]`, not the old `shadow`.
  - `S_ON`:
    - Outputs hold, `cnt` increments.
    - When `cnt==SCAN_DIV-1`: go to `S_BLANK`, `cnt<=0`, `dig_n<=4'b1111`, `seg<=7'h7F`, `digit<=digit+1` (wraps 3→0).
- Frame latch vs. CPU write: if a write coincides with the frame latch cycle, `shadow` takes the old `pend`. The new value appears in the next frame.
- A write never alters the frame currently being displayed.

## Timing

- Reset values:
  - `state=S_BLANK`, `digit=0`, `cnt=0`, `pend=0`, `shadow=0`
  - `seg=7'h7F`, `dig_n=4'b1111`, `to_cpu=16'h0000`
- Reset asserted at any time, including mid-`S_ON`, forces these values immediately (asynchronous). Scanning restarts from digit 0 blank phase after release.
- `seg` and `dig_n` are registered and change on the same edge; there is no segment/enable skew.
- First digit lights on edge `BLANK_DIV` after reset release (edges counted from 1).
- Digit k lit window: `SCAN_DIV` cycles. Blank gap: `BLANK_DIV` cycles.
- Frame period: `4*(SCAN_DIV+BLANK_DIV)` cycles.
- `to_cpu` reflects a write in the cycle after the write edge.
- Write-to-display latency: up to one frame plus `BLANK_DIV` cycles.

## Configuration

- Macro `DEV_7SEG_SCAN_LZB_EN` (leading-zero blanking).
- Defined:
  - During `S_ON`, digit k∈{3,2,1} outputs `seg=7'h7F` if every `shadow` nibble from 3 down to k is zero. `dig_n` still follows the normal pattern.
  - Digit 0 is always shown.
  - For digit 0's lit phase, the test uses `pend`, matching the latch.
- Undefined: all four digits always display their nibble (0x0042 shows "0042").

## Test plan

Parameters for all tests: `SCAN_DIV=4`, `BLANK_DIV=2`, frame period 24 cycles.

1. **Reset:** assert `rst` → `seg=7'h7F`, `dig_n=4'hF`, `to_cpu=0`. After release, `dig_n=4'b1110` with `seg=0x40` after 2 edges, held 4 cycles, then 2 cycles of `4'hF`/`7'h7F`.
2. **Write and display:** write 0x1234 with `cs=1`, `we=1` mid-frame → `to_cpu=0x1234` next cycle. The current frame keeps its old digits. The next frame shows digit0=0x19, digit1=0x30, digit2=0x24, digit3=0x79 in order, each after a 2-cycle blank.
3. **Write collision:** write 0xFFFF exactly on the digit-0 latch edge → that frame displays the previous value. 0xFFFF (all digits `seg=0x0E`) appears in the following frame.
4. **Ignored writes:** `we=1` with `cs=0`, or `cs=1` with `we=0`, data 0xABCD → `pend` and `to_cpu` unchanged.
5. **Reset mid-scan:** assert `rst` during digit 2 `S_ON` → outputs blank immediately with no clock edge needed. After release, the scan restarts at digit 0 and `to_cpu=0`.
6. **Leading-zero blanking:** write 0x0042. With `DEV_7SEG_SCAN_LZB_EN` defined: digits 3 and 2 `seg=7'h7F`, digit1=0x19, digit0=0x24. Without the macro: digits 3 and 2 show `seg=0x40`.

Source files
------------

// File: rtl/dev_interface_7seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame shadow latch on the PICO16a bus.
// Optional leading-zero blanking: define DEV_7SEG_SCAN_LZB_EN.
module dev_interface_7seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_DIV = 500
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [15:0] from_cpu,
    input  logic        cs,
    input  logic        we,
    output logic [15:0] to_cpu,
    output logic [6:0]  seg,
    output logic [3:0]  dig_n
);

    localparam int MAX_DIV = (SCAN_DIV > BLANK_DIV) ? SCAN_DIV : BLANK_DIV;
    localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_DIV - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {S_BLANK, S_ON} state_t;

    state_t           state, state_nx;
    logic [15:0]      pend;
    logic [15:0]      shadow, shadow_nx;
    logic [1:0]       digit, digit_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [6:0]       seg_nx;
    logic [3:0]       dig_n_nx;
    logic [15:0]      frame_val;
    logic [3:0]       nib;
    logic             lz_blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    // Bus write: one-cycle strobe, accepted whenever cs && we at a rising edge; no stall.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) pend <= 16'h0000;
        else if (cs && we) pend <= from_cpu;
    end

    assign to_cpu = pend;

    // Digit 0 lights on the same edge shadow is loaded, so it must read pend directly.
    always_comb begin
        frame_val = (digit == 2'd0) ? pend : shadow;
        nib       = frame_val[{digit, 2'b00} +: 4];
        lz_blank  = 1'b0;
`ifdef DEV_7SEG_SCAN_LZB_EN
        case (digit)
            2'd3:    lz_blank = (frame_val[15:12] == 4'h0);
            2'd2:    lz_blank = (frame_val[15:8] == 8'h00);
            2'd1:    lz_blank = (frame_val[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        digit_nx  = digit;
        shadow_nx = shadow;
        seg_nx    = seg;
        dig_n_nx  = dig_n;
        case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = S_ON;
                    cnt_nx   = '0;
                    dig_n_nx = ~(4'b0001 << digit);
                    seg_nx   = lz_blank ? 7'h7F : hex_decode(nib);
                    if (digit == 2'd0) shadow_nx = pend;
                end
            end
            S_ON: begin
                if (cnt == SCAN_LAST) begin
                    state_nx = S_BLANK;
                    cnt_nx   = '0;
                    dig_n_nx = 4'b1111;
                    seg_nx   = 7'h7F;
                    digit_nx = digit + 2'd1;
                end
            end
            default: state_nx = S_BLANK;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) state <= S_BLANK;
        else     state <= state_nx;
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            digit  <= 2'd0;
            shadow <= 16'h0000;
            seg    <= 7'h7F;
            dig_n  <= 4'b1111;
        end else begin
            cnt    <= cnt_nx;
            digit  <= digit_nx;
            shadow <= shadow_nx;
            seg    <= seg_nx;
            dig_n  <= dig_n_nx;
        end
    end

endmodule

// File: tb/tb_dev_interface_7seg_scan.sv
// Self-checking bench for dev_interface_7seg_scan: frame-timing model plus directed literal checks.
module tb_dev_interface_7seg_scan;

    localparam int SCAN  = 4;
    localparam int BLANK = 2;
    localparam int DIG_P = SCAN + BLANK;
    localparam int FRAME = 4 * DIG_P;

    logic        cpu_clk;
    logic        rst;
    logic [15:0] from_cpu;
    logic        cs;
    logic        we;
    logic [15:0] to_cpu;
    logic [6:0]  seg;
    logic [3:0]  dig_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: edges since reset release, pending and frame values.
    int          m_t      = 0;
    logic [15:0] m_pend   = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_valid  = 1'b0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef DEV_7SEG_SCAN_LZB_EN
    localparam logic [6:0] LZ_ZERO = 7'h7F;
`else
    localparam logic [6:0] LZ_ZERO = 7'h40;
`endif

    dev_interface_7seg_scan #(.SCAN_DIV(SCAN), .BLANK_DIV(BLANK)) dut (
        .cpu_clk  (cpu_clk),
        .rst      (rst),
        .from_cpu (from_cpu),
        .cs       (cs),
        .we       (we),
        .to_cpu   (to_cpu),
        .seg      (seg),
        .dig_n    (dig_n)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, m_t);
    endtask

    // Frame latch is evaluated before the write so a colliding write lands in the next frame.
    always @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            m_t      = 0;
            m_pend   = 16'h0;
            m_shadow = 16'h0;
        end else begin
            m_t = m_t + 1;
            if (m_t % FRAME == BLANK) m_shadow = m_pend;
            if (cs && we) m_pend = from_cpu;
        end
        m_valid = 1'b1;
    end

    always @(negedge cpu_clk) begin
        int q, dg, r;
        logic [6:0] e_seg;
        logic [3:0] e_dig;
        if (m_valid) begin
            q  = m_t % FRAME;
            dg = q / DIG_P;
            r  = q % DIG_P;
            if (r >= BLANK) begin
                e_dig = ~(4'b0001 << dg);
                e_seg = dec_tab[(m_shadow >> (4 * dg)) & 16'hF];
`ifdef DEV_7SEG_SCAN_LZB_EN
                if (dg != 0 && (m_shadow >> (4 * dg)) == 16'h0) e_seg = 7'h7F;
`endif
            end else begin
                e_dig = 4'b1111;
                e_seg = 7'h7F;
            end
            check("model_seg", {9'h0, seg}, {9'h0, e_seg});
            check("model_dig_n", {12'h0, dig_n}, {12'h0, e_dig});
            check("model_to_cpu", to_cpu, m_pend);
        end
    end

    task automatic wait_t(input int target);
        int budget = 200;
        while (m_t < target && budget > 0) begin
            @(negedge cpu_clk);
            budget--;
        end
        if (m_t < target) begin
            n_checks++;
            $display("FAIL wait_t: reached t=%0d required t=%0d", m_t, target);
        end
    endtask

    task automatic bus_write(input logic c, input logic w, input logic [15:0] d);
        cs = c;
        we = w;
        from_cpu = d;
        @(negedge cpu_clk);
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [6:0] s, input logic [3:0] d);
        check({name, "_seg"}, {9'h0, seg}, {9'h0, s});
        check({name, "_dig_n"}, {12'h0, dig_n}, {12'h0, d});
    endtask

    initial begin
        rst = 1'b1;
        cs = 1'b0;
        we = 1'b0;
        from_cpu = 16'h0;
        repeat (2) @(negedge cpu_clk);
        expect_out("reset", 7'h7F, 4'hF);
        check("reset_to_cpu", to_cpu, 16'h0000);
        rst = 1'b0;

        wait_t(1); expect_out("first_blank", 7'h7F, 4'hF);
        wait_t(2); expect_out("first_lit", 7'h40, 4'hE);
        wait_t(5); expect_out("first_hold", 7'h40, 4'hE);
        wait_t(6); expect_out("first_gap", 7'h7F, 4'hF);

        bus_write(1'b1, 1'b1, 16'h1234);
        check("write_to_cpu", to_cpu, 16'h1234);
        wait_t(8);  expect_out("old_frame_d1", LZ_ZERO, 4'hD);
        wait_t(26); expect_out("f1_d0", 7'h19, 4'hE);
        wait_t(32); expect_out("f1_d1", 7'h30, 4'hD);
        wait_t(38); expect_out("f1_d2", 7'h24, 4'hB);
        wait_t(44); expect_out("f1_d3", 7'h79, 4'h7);

        wait_t(49);
        bus_write(1'b1, 1'b1, 16'hFFFF);
        expect_out("collide_d0", 7'h19, 4'hE);
        check("collide_to_cpu", to_cpu, 16'hFFFF);
        wait_t(56); expect_out("collide_d1", 7'h30, 4'hD);
        wait_t(74); expect_out("ffff_d0", 7'h0E, 4'hE);
        wait_t(80); expect_out("ffff_d1", 7'h0E, 4'hD);

        bus_write(1'b0, 1'b1, 16'hABCD);
        check("ignore_cs0", to_cpu, 16'hFFFF);
        bus_write(1'b1, 1'b0, 16'hABCD);
        check("ignore_we0", to_cpu, 16'hFFFF);
        wait_t(98); expect_out("ignore_d0", 7'h0E, 4'hE);

        wait_t(110); expect_out("pre_rst_d2", 7'h0E, 4'hB);
        #1 rst = 1'b1;
        #1;
        expect_out("async_rst", 7'h7F, 4'hF);
        check("async_rst_to_cpu", to_cpu, 16'h0000);
        repeat (2) @(negedge cpu_clk);
        rst = 1'b0;
        wait_t(2); expect_out("restart_d0", 7'h40, 4'hE);
        check("restart_to_cpu", to_cpu, 16'h0000);

        bus_write(1'b1, 1'b1, 16'h0042);
        check("lz_to_cpu", to_cpu, 16'h0042);
        wait_t(26); expect_out("lz_d0", 7'h24, 4'hE);
        wait_t(32); expect_out("lz_d1", 7'h19, 4'hD);
        wait_t(38); expect_out("lz_d2", LZ_ZERO, 4'hB);
        wait_t(44); expect_out("lz_d3", LZ_ZERO, 4'h7);

        @(negedge cpu_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
